// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared state/op encodings and ALU latency constants for alu_rr_scheduler.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } sched_state_t;

  typedef enum logic [2:0] {
    OP_MUL  = 3'b000,
    OP_ADD,
    OP_SUB,
    OP_ADDC,
    OP_OR,
    OP_AND,
    OP_XOR,
    OP_NOT
  } alu_op_t;

  // Cycles from start_op to end_op on the shared ALU.
  localparam int LAT_SINGLE = 1;
  localparam int LAT_MUL    = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; searches from i_ptr+1 with wraparound.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_valid[w_j]) begin
        o_any        = 1'b1;
        o_idx        = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one multi-cycle ALU among NUM_REQ requesters.
// Optional WAIT-state watchdog is compiled in with `define ALU_SCHED_WDOG_EN.
//
//   state   | meaning
//   S_IDLE  | arbitrate; on a grant latch operands and requester ID
//   S_ISSUE | pulse alu_start for one cycle
//   S_WAIT  | operands held; wait for alu_end (or watchdog expiry)
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_WIDTH     = 16,
  parameter  int RESULT_WIDTH   = 32,
  parameter  int TIMEOUT_CYCLES = 15,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]          req_op,
  output logic [DATA_WIDTH-1:0]         alu_a,
  output logic [DATA_WIDTH-1:0]         alu_b,
  output logic [2:0]                    alu_op,
  output logic                          alu_start,
  input  logic                          alu_end,
  input  logic [RESULT_WIDTH-1:0]       alu_result,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [RESULT_WIDTH-1:0]       rsp_data,
  output logic                          rsp_err,
  output logic [15:0]                   ops_done
);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("alu_rr_scheduler: unsupported parameter set");
  end

  sched_state_t            r_state, w_state_nxt;
  logic [NUM_REQ-1:0]      w_grant;
  logic [ID_W-1:0]         w_idx, r_ptr, r_id;
  logic                    w_any, w_accept, w_done, w_timeout;
  logic [DATA_WIDTH-1:0]   w_req_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]   w_req_b [NUM_REQ];
  logic [2:0]              w_req_op [NUM_REQ];
  logic [DATA_WIDTH-1:0]   r_alu_a, r_alu_b;
  logic [2:0]              r_alu_op;
  logic                    r_rsp_valid, r_rsp_err;
  logic [ID_W-1:0]         r_rsp_id;
  logic [RESULT_WIDTH-1:0] r_rsp_data;
  logic [15:0]             r_ops_done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_a[g]  = req_a[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_req_b[g]  = req_b[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_req_op[g] = req_op[g*3 +: 3];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_accept  = (r_state == S_IDLE) && w_any;
  assign w_done    = (r_state == S_WAIT) && alu_end;
  assign req_ready = (r_state == S_IDLE) ? w_grant : '0;

`ifdef ALU_SCHED_WDOG_EN
  logic [7:0] r_wd_cnt;

  always_ff @(posedge clk) begin
    if (rst || r_state == S_ISSUE) r_wd_cnt <= '0;
    else if (r_state == S_WAIT)    r_wd_cnt <= r_wd_cnt + 8'd1;
  end

  // Counter reads N-1 during the Nth WAIT cycle; a coincident alu_end takes precedence.
  assign w_timeout = (r_state == S_WAIT) && !alu_end && (r_wd_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (alu_end || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_id        <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_ops_done  <= '0;
    end else begin
      r_rsp_valid <= w_done || w_timeout;
      r_rsp_err   <= w_timeout;
      if (w_accept) begin
        r_alu_a  <= w_req_a[w_idx];
        r_alu_b  <= w_req_b[w_idx];
        r_alu_op <= w_req_op[w_idx];
        r_id     <= w_idx;
        r_ptr    <= w_idx;
      end
      if (w_done) begin
        r_rsp_data <= alu_result;
        r_rsp_id   <= r_id;
      end else if (w_timeout) begin
        r_rsp_data <= '0;
        r_rsp_id   <= r_id;
      end
      r_ops_done <= (w_done && (r_ops_done != 16'hFFFF)) ? r_ops_done + 16'd1 : r_ops_done;
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign alu_start = (r_state == S_ISSUE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed bench for alu_rr_scheduler with a behavioural ALU partner.
// Watchdog expectations follow `define ALU_SCHED_WDOG_EN.
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int RW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*3-1:0]  req_op;
  logic [DW-1:0]   alu_a, alu_b;
  logic [2:0]      alu_op;
  logic            alu_start, alu_end;
  logic [RW-1:0]   alu_result;
  logic            rsp_valid, rsp_err;
  logic [1:0]      rsp_id;
  logic [RW-1:0]   rsp_data;
  logic [15:0]     ops_done;

  logic [DW-1:0] tb_a  [N];
  logic [DW-1:0] tb_b  [N];
  logic [2:0]    tb_op [N];

  int checks = 0;
  int failures = 0;

  int          m_cnt;
  logic [RW-1:0] m_res;
  logic        hold_end = 1'b0;

  logic [3:0]  rdy;
  int          lat;
  logic [1:0]  got_id;
  logic [31:0] got_data;
  logic        got_err;

  logic [15:0] rr_a [4] = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
  logic [15:0] rr_b [4] = '{16'h0002, 16'h0020, 16'h0200, 16'h2000};
  logic [31:0] rr_d [4] = '{32'h0000_0003, 32'h0000_0030, 32'h0000_0300, 32'h0000_3000};

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[g*DW +: DW] = tb_a[g];
    assign req_b[g*DW +: DW] = tb_b[g];
    assign req_op[g*3 +: 3]  = tb_op[g];
  end

  alu_rr_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_end    (alu_end),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
    case (op)
      3'b000:  return 32'(a) * 32'(b);
      3'b001:  return 32'(a) + 32'(b);
      3'b010:  return 32'(a) - 32'(b);
      3'b011:  return 32'(a) + 32'(b) + 32'd1;
      3'b100:  return {16'h0, a | b};
      3'b101:  return {16'h0, a & b};
      3'b110:  return {16'h0, a ^ b};
      default: return {16'h0, ~a};
    endcase
  endfunction

  // ALU partner: end_op LAT cycles after start_op; hold_end freezes a pending end_op.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
      m_res <= '0;
    end else if (alu_start) begin
      m_cnt <= (alu_op == OP_MUL) ? LAT_MUL : LAT_SINGLE;
      m_res <= alu_model(alu_a, alu_b, alu_op);
    end else if (m_cnt > 1 || (m_cnt == 1 && !hold_end)) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign alu_end    = (m_cnt == 1) && !hold_end;
  assign alu_result = m_res;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op);
    tb_a[i]  = a;
    tb_b[i]  = b;
    tb_op[i] = op;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    hold_end = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Issue one request from requester i while IDLE; returns cycles until rsp_valid (-1 if none in 40).
  task automatic issue_and_wait(input int i, input logic [15:0] a, input logic [15:0] b,
                                input logic [2:0] op, output logic [3:0] o_rdy, output int o_lat,
                                output logic [1:0] o_id, output logic [31:0] o_data,
                                output logic o_err);
    set_req(i, a, b, op);
    req_valid = 4'(1 << i);
    #1;
    o_rdy  = req_ready;
    o_lat  = -1;
    o_id   = '0;
    o_data = '0;
    o_err  = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      req_valid = '0;
      if (rsp_valid) begin
        o_lat  = n;
        o_id   = rsp_id;
        o_data = rsp_data;
        o_err  = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if ({alu_start, rsp_valid, rsp_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {alu_start, rsp_valid, rsp_err}); end
    checks++; if ({alu_a, alu_b, alu_op} !== 35'd0) begin failures++; $display("FAIL reset_alu_regs got=%h exp=0", {alu_a, alu_b, alu_op}); end
    checks++; if ({rsp_id, rsp_data} !== 34'd0) begin failures++; $display("FAIL reset_rsp got=%h exp=0", {rsp_id, rsp_data}); end
    checks++; if (ops_done !== 16'h0000) begin failures++; $display("FAIL reset_ops_done got=%h exp=0000", ops_done); end
  endtask

  task automatic test_single_op();
    set_req(0, 16'd3, 16'd5, OP_ADD);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL t1_ready got=%b exp=0001", req_ready); end
    cyc();
    req_valid = '0;
    #1;
    checks++; if (alu_start !== 1'b1) begin failures++; $display("FAIL t1_start got=%b exp=1", alu_start); end
    checks++; if ({alu_a, alu_b, alu_op} !== {16'd3, 16'd5, 3'b001}) begin failures++; $display("FAIL t1_operands got=%h/%h/%b exp=0003/0005/001", alu_a, alu_b, alu_op); end
    cyc();
    checks++; if ({alu_start, rsp_valid} !== 2'b00) begin failures++; $display("FAIL t1_wait got=%b exp=00", {alu_start, rsp_valid}); end
    cyc();
    checks++; if ({rsp_valid, rsp_err, rsp_id} !== {1'b1, 1'b0, 2'd0}) begin failures++; $display("FAIL t1_rsp got v=%b e=%b id=%0d exp v=1 e=0 id=0", rsp_valid, rsp_err, rsp_id); end
    checks++; if (rsp_data !== 32'h0000_0008) begin failures++; $display("FAIL t1_data got=%h exp=00000008", rsp_data); end
    checks++; if (ops_done !== 16'd1) begin failures++; $display("FAIL t1_ops_done got=%0d exp=1", ops_done); end
    cyc();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL t1_rsp_pulse got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_mul_hold();
    set_req(2, 16'h0010, 16'h0020, OP_MUL);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL t2_ready got=%b exp=0100", req_ready); end
    cyc();
    req_valid = '0;
    #1;
    checks++; if ({alu_start, alu_a, alu_b, alu_op} !== {1'b1, 16'h0010, 16'h0020, 3'b000}) begin failures++; $display("FAIL t2_issue got=%b %h %h %b", alu_start, alu_a, alu_b, alu_op); end
    for (int n = 2; n <= 4; n++) begin
      cyc();
      // Requesters change their lines while the op is in flight.
      req_valid = 4'b0110;
      set_req(2, 16'hFFFF, 16'hFFFF, OP_NOT);
      #1;
      checks++;
      if ({alu_a, alu_b, alu_op, req_ready, rsp_valid, alu_start} !== {16'h0010, 16'h0020, 3'b000, 4'b0000, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL t2_hold_T+%0d got a=%h b=%h op=%b rdy=%b v=%b st=%b", n, alu_a, alu_b, alu_op, req_ready, rsp_valid, alu_start);
      end
    end
    cyc();
    req_valid = '0;
    #1;
    checks++; if ({rsp_valid, rsp_id} !== {1'b1, 2'd2}) begin failures++; $display("FAIL t2_rsp got v=%b id=%0d exp v=1 id=2", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== 32'h0000_0200) begin failures++; $display("FAIL t2_data got=%h exp=00000200", rsp_data); end
    checks++; if (ops_done !== 16'd2) begin failures++; $display("FAIL t2_ops_done got=%0d exp=2", ops_done); end
  endtask

  task automatic test_back_to_back();
    int g, p;
    apply_reset();
    for (int k = 0; k < 4; k++) set_req(k, rr_a[k], rr_b[k], OP_OR);
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      checks++; if (req_ready !== 4'(1 << g)) begin failures++; $display("FAIL t3_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << g)); end
      if (k > 0) begin
        p = (k - 1) % 4;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(p), rr_d[p]}) begin
          failures++;
          $display("FAIL t3_rsp%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", k - 1, rsp_valid, rsp_id, rsp_data, p, rr_d[p]);
        end
      end
      cyc();
      if (k == 4) req_valid = '0;
      cyc();
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL t3_bubble%0d got=%b exp=0", k, rsp_valid); end
      cyc();
    end
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 32'h0000_0003}) begin failures++; $display("FAIL t3_rsp4 got v=%b id=%0d d=%h exp v=1 id=0 d=00000003", rsp_valid, rsp_id, rsp_data); end
    checks++; if (ops_done !== 16'd5) begin failures++; $display("FAIL t3_ops_done got=%0d exp=5", ops_done); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    set_req(1, 16'd7, 16'd9, OP_MUL);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL t4_ready got=%b exp=0010", req_ready); end
    cyc();
    req_valid = '0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    checks++; if ({req_ready, alu_start, rsp_valid, rsp_err} !== 7'd0) begin failures++; $display("FAIL t4_flags got=%b exp=0", {req_ready, alu_start, rsp_valid, rsp_err}); end
    checks++; if ({alu_a, alu_b, alu_op} !== 35'd0) begin failures++; $display("FAIL t4_alu_regs got=%h exp=0", {alu_a, alu_b, alu_op}); end
    checks++; if ({rsp_id, rsp_data, ops_done} !== 50'd0) begin failures++; $display("FAIL t4_rsp_regs got id=%0d d=%h ops=%0d exp 0", rsp_id, rsp_data, ops_done); end
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      cyc();
      if (rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL t4_dropped_rsp got=1 exp=0"); end
    for (int k = 0; k < 4; k++) set_req(k, 16'(k + 1), 16'd1, OP_ADD);
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL t4_prio got=%b exp=0001", req_ready); end
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 32'd2}) begin failures++; $display("FAIL t4_rsp got v=%b id=%0d d=%h exp v=1 id=0 d=00000002", rsp_valid, rsp_id, rsp_data); end
  endtask

  task automatic test_wdog();
    hold_end = 1'b1;
    issue_and_wait(3, 16'h0100, 16'h0023, OP_ADD, rdy, lat, got_id, got_data, got_err);
    checks++; if (rdy !== 4'b1000) begin failures++; $display("FAIL t5_ready got=%b exp=1000", rdy); end
`ifdef ALU_SCHED_WDOG_EN
    checks++; if (lat !== 17) begin failures++; $display("FAIL t5_timeout_lat got=%0d exp=17", lat); end
    checks++; if ({got_err, got_id, got_data} !== {1'b1, 2'd3, 32'd0}) begin failures++; $display("FAIL t5_timeout_rsp got e=%b id=%0d d=%h exp e=1 id=3 d=0", got_err, got_id, got_data); end
    checks++; if (ops_done !== 16'd1) begin failures++; $display("FAIL t5_ops_done got=%0d exp=1", ops_done); end
    hold_end = 1'b0;
    cyc();
    cyc();
    checks++; if ({rsp_valid, rsp_err} !== 2'b00) begin failures++; $display("FAIL t5_late_end got=%b exp=00", {rsp_valid, rsp_err}); end
`else
    checks++; if (lat !== -1) begin failures++; $display("FAIL t5_held_wait got=%0d exp=-1", lat); end
    hold_end = 1'b0;
    cyc();
    checks++; if ({rsp_valid, rsp_err, rsp_id, rsp_data} !== {1'b1, 1'b0, 2'd3, 32'h0000_0123}) begin failures++; $display("FAIL t5_rsp got v=%b e=%b id=%0d d=%h exp v=1 e=0 id=3 d=00000123", rsp_valid, rsp_err, rsp_id, rsp_data); end
    checks++; if (ops_done !== 16'd2) begin failures++; $display("FAIL t5_ops_done got=%0d exp=2", ops_done); end
`endif
  endtask

  task automatic test_saturate();
    force dut.r_ops_done = 16'hFFFE;
    cyc();
    release dut.r_ops_done;
    for (int n = 0; n < 3; n++) begin
      issue_and_wait(n, 16'(n + 1), 16'd2, OP_ADD, rdy, lat, got_id, got_data, got_err);
      checks++; if ({lat, got_id, got_data} !== {32'd3, 2'(n), 32'(n + 3)}) begin failures++; $display("FAIL t6_op%0d got lat=%0d id=%0d d=%h exp lat=3 id=%0d d=%h", n, lat, got_id, got_data, n, 32'(n + 3)); end
      checks++; if (ops_done !== 16'hFFFF) begin failures++; $display("FAIL t6_sat%0d got=%h exp=ffff", n, ops_done); end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) set_req(k, '0, '0, '0);
    test_reset();
    test_single_op();
    test_mul_hold();
    test_back_to_back();
    test_reset_mid();
    test_wdog();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
